// File: rtl/led_pattern_sched.sv
// Single-LED scheduler: fixed-priority owner selection (index 0 highest) with
// a minimum hold before preemption, a shared blink prescaler, and a registered
// LED drive that always matches the registered one-hot grant.
module led_pattern_sched #(
   parameter int NREQ  = 4,
   parameter int CBITS = 14,
   parameter int HOLD  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [2*NREQ-1:0]   mode,
   output logic                led,
   output logic [NREQ-1:0]     grant,
   output logic                tick,
   output logic                busy
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   state_t            state, state_n;
   logic [CBITS-1:0]  cnt;
   logic [IW-1:0]     owner, owner_n;
   logic [3:0]        hold, hold_n;
   logic [2:0]        phase, phase_n;
   logic [NREQ-1:0]   grant_n;
   logic              led_n;
   logic              any_req;
   logic              higher_req;
   logic              load;
   logic [IW-1:0]     pick;

   // LED level for a pattern code at a given blink phase.
   function automatic logic pattern(input logic [1:0] m, input logic [2:0] ph);
      case (m)
         2'b00:   pattern = 1'b0;
         2'b01:   pattern = 1'b1;
         2'b10:   pattern = ~ph[2];
         default: pattern = ~ph[0];
      endcase
   endfunction

   // Free-running prescaler; tick is a registered one-cycle pulse per wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= cnt + 1'b1;
         tick <= (cnt == '1);
      end
   end

   // Lowest set request index wins arbitration.
   always_comb begin
      pick = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) pick = IW'(i);
      end
   end

   assign any_req    = |req;
   // Lowest pending index below the owner means a higher-priority request exists.
   assign higher_req = any_req && (pick < owner);

   // Next-state, owner, hold/phase bookkeeping and registered output values.
   always_comb begin
      state_n = state;
      owner_n = owner;
      hold_n  = hold;
      phase_n = phase;
      load    = 1'b0;
      grant_n = '0;
      led_n   = 1'b0;

      case (state)
         IDLE: begin
            if (any_req) load = 1'b1;
         end
         SERVE: begin
            if (!req[owner]) begin
               // Release ignores hold; re-arbitrate among what is left.
               if (any_req) begin
                  load = 1'b1;
               end else begin
                  state_n = IDLE;
                  hold_n  = '0;
                  phase_n = '0;
               end
            end else if (higher_req && hold == 4'd0) begin
               load = 1'b1;
            end else if (tick) begin
               phase_n = phase + 3'd1;
               hold_n  = (hold == 4'd0) ? 4'd0 : hold - 4'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      // A new grant restarts the blink and the hold window; a coincident tick is dropped.
      if (load) begin
         state_n = SERVE;
         owner_n = pick;
         hold_n  = 4'(HOLD);
         phase_n = '0;
      end

      if (state_n == SERVE) begin
         grant_n[owner_n] = 1'b1;
         led_n            = pattern(mode[2*owner_n +: 2], phase_n);
      end
   end

   // State register; grant and led update on the same edge so they track one owner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         owner <= '0;
         hold  <= '0;
         phase <= '0;
         grant <= '0;
         led   <= 1'b0;
      end else begin
         state <= state_n;
         owner <= owner_n;
         hold  <= hold_n;
         phase <= phase_n;
         grant <= grant_n;
         led   <= led_n;
      end
   end

   assign busy = |grant;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Bench for led_pattern_sched with an 8-cycle tick and a hold of two ticks.
// Directed scenarios check exact cycle positions; a random run uses a reference model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_led_pattern_sched;

   localparam int NREQ  = 4;
   localparam int CBITS = 3;
   localparam int HOLD  = 2;
   localparam int PER   = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [7:0] mode;
   logic       led;
   logic [3:0] grant;
   logic       tick;
   logic       busy;

   int vectors = 0;
   int errors  = 0;

   // Reference model: owner (-1 idle), ticks counted since the grant, edges since reset.
   int   m_owner;
   int   m_ticks;
   int   m_cyc;
   logic m_led;

   led_pattern_sched #(.NREQ(NREQ), .CBITS(CBITS), .HOLD(HOLD)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .mode  (mode),
      .led   (led),
      .grant (grant),
      .tick  (tick),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   function automatic int lowest(input logic [3:0] r);
      for (int i = 0; i < 4; i++) if (r[i]) return i;
      return -1;
   endfunction

   function automatic int m_hold();
      int h;
      h = HOLD - m_ticks;
      return (h < 0) ? 0 : h;
   endfunction

   function automatic logic m_tick_now();
      return (m_cyc > 0) && (m_cyc % PER == 0);
   endfunction

   function automatic logic [6:0] exp_vec();
      logic [3:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return {g, m_led, (m_owner >= 0), m_tick_now()};
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ticks = 0;
      m_cyc   = 0;
      m_led   = 1'b0;
   endtask

   // Applies the scheduling rules for one clock edge with the inputs present before it.
   task automatic model_edge(input logic [3:0] r, input logic [7:0] md);
      logic t;
      int   lo;
      bit   regrant;
      int   ph;
      t       = m_tick_now();
      lo      = lowest(r);
      regrant = 0;
      if (m_owner < 0) regrant = (lo >= 0);
      else if (!r[m_owner]) begin
         if (lo >= 0) regrant = 1;
         else m_owner = -1;
      end else if (lo >= 0 && lo < m_owner && m_hold() == 0) regrant = 1;
      else if (t) m_ticks++;
      if (regrant) begin
         m_owner = lo;
         m_ticks = 0;
      end
      m_cyc++;
      ph = m_ticks % 8;
      if (m_owner < 0) m_led = 1'b0;
      else begin
         case (md[2*m_owner +: 2])
            2'b00:   m_led = 1'b0;
            2'b01:   m_led = 1'b1;
            2'b10:   m_led = (ph < 4);
            default: m_led = (ph % 2 == 0);
         endcase
      end
   endtask

   task automatic step();
      model_edge(req, mode);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // Raises rst mid-cycle; returns with rst still high so the caller can sample.
   task automatic pulse_rst();
      #2;
      rst = 1'b1;
      #1;
   endtask

   // Drops rst before the next rising edge, half a cycle after it rose.
   task automatic release_rst();
      #4;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      req  = 4'hF;
      mode = 8'hFF;
      #2;
      vectors++;
      if ({grant, led, busy, tick} !== 7'b0) begin
         errors++;
         $display("FAIL reset_async: got %b, want 0000000", {grant, led, busy, tick});
      end
      @(posedge clk);
      #1;
      vectors++;
      if ({grant, led, busy, tick} !== 7'b0) begin
         errors++;
         $display("FAIL reset_held: got %b, want 0000000", {grant, led, busy, tick});
      end
      rst = 1'b0;
      req = 4'h0;
      model_reset();
      for (int k = 1; k <= 32; k++) begin
         step();
         vectors++;
         if (tick !== (k % PER == 0) || grant !== 4'b0) begin
            errors++;
            $display("FAIL tick_period: edge %0d tick=%b grant=%b, want tick=%b grant=0000",
                     k, tick, grant, (k % PER == 0));
         end
      end
      pulse_rst();
      vectors++;
      if (tick !== 1'b0) begin
         errors++;
         $display("FAIL tick_reset_clear: got tick=%b, want 0", tick);
      end
      release_rst();
      for (int k = 1; k <= 9; k++) begin
         step();
         vectors++;
         if (tick !== (k == 8)) begin
            errors++;
            $display("FAIL tick_restart: edge %0d tick=%b, want %b", k, tick, (k == 8));
         end
      end
   endtask

   task automatic test_fast_blink();
      do_reset();
      req  = 4'b0100;
      mode = 8'b00_11_00_00;
      for (int e = 1; e <= 40; e++) begin
         step();
         vectors++;
         if (grant !== 4'b0100 || busy !== 1'b1 || led !== (((e - 1) / 8) % 2 == 0)) begin
            errors++;
            $display("FAIL fast_blink: edge %0d grant=%b busy=%b led=%b, want 0100 1 %b",
                     e, grant, busy, led, (((e - 1) / 8) % 2 == 0));
         end
      end
   endtask

   task automatic test_slow_blink();
      int on_cnt;
      on_cnt = 0;
      do_reset();
      req  = 4'b0010;
      mode = 8'b00_00_10_00;
      for (int e = 1; e <= 80; e++) begin
         step();
         if (led === 1'b1 && e <= 40) on_cnt++;
         vectors++;
         if (grant !== 4'b0010 || led !== (((e - 1) / 8) % 8 < 4)) begin
            errors++;
            $display("FAIL slow_blink: edge %0d grant=%b led=%b, want 0010 %b",
                     e, grant, led, (((e - 1) / 8) % 8 < 4));
         end
      end
      vectors++;
      if (on_cnt !== 32) begin
         errors++;
         $display("FAIL slow_on_len: got %0d cycles on, want 32", on_cnt);
      end
   endtask

   task automatic test_preempt();
      int ticks_seen;
      int sw_edge;
      ticks_seen = 0;
      sw_edge    = -1;
      do_reset();
      req  = 4'b0100;
      mode = 8'b00_11_00_01;
      step();
      vectors++;
      if (grant !== 4'b0100) begin
         errors++;
         $display("FAIL preempt_first: grant=%b, want 0100", grant);
      end
      req = 4'b0101;
      for (int e = 2; e <= 40 && sw_edge < 0; e++) begin
         step();
         if (grant === 4'b0100 && tick === 1'b1) ticks_seen++;
         if (grant !== 4'b0100) sw_edge = e;
      end
      vectors++;
      if (sw_edge != 18 || grant !== 4'b0001 || led !== 1'b1 || ticks_seen != 2) begin
         errors++;
         $display("FAIL preempt_hold: edge=%0d grant=%b led=%b ticks=%0d, want 18 0001 1 2",
                  sw_edge, grant, led, ticks_seen);
      end
      req = 4'b1101;
      for (int e = 0; e < 12; e++) begin
         step();
         vectors++;
         if (grant !== 4'b0001 || led !== 1'b1) begin
            errors++;
            $display("FAIL no_low_preempt: grant=%b led=%b, want 0001 1", grant, led);
         end
      end
   endtask

   task automatic test_release();
      do_reset();
      req  = 4'b1010;
      mode = 8'b11_00_10_00;
      step();
      vectors++;
      if (grant !== 4'b0010 || led !== 1'b1) begin
         errors++;
         $display("FAIL release_first: grant=%b led=%b, want 0010 1", grant, led);
      end
      req = 4'b1000;
      for (int e = 2; e <= 9; e++) begin
         step();
         vectors++;
         if (grant !== 4'b1000 || busy !== 1'b1 || led !== (e <= 8)) begin
            errors++;
            $display("FAIL release_handover: edge %0d grant=%b busy=%b led=%b, want 1000 1 %b",
                     e, grant, busy, led, (e <= 8));
         end
      end
      req = 4'b0000;
      step();
      vectors++;
      if ({grant, led, busy} !== 6'b0) begin
         errors++;
         $display("FAIL release_idle: got %b, want 000000", {grant, led, busy});
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req  = 4'b0001;
      mode = 8'b00_00_00_11;
      for (int e = 1; e <= 4; e++) step();
      vectors++;
      if (grant !== 4'b0001 || led !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: grant=%b led=%b, want 0001 1", grant, led);
      end
      pulse_rst();
      vectors++;
      if ({grant, led, busy} !== 6'b0) begin
         errors++;
         $display("FAIL async_clear: got %b, want 000000", {grant, led, busy});
      end
      release_rst();
      for (int e = 1; e <= 9; e++) begin
         step();
         vectors++;
         if (grant !== 4'b0001 || led !== (e <= 8)) begin
            errors++;
            $display("FAIL async_restart: edge %0d grant=%b led=%b, want 0001 %b",
                     e, grant, led, (e <= 8));
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      req  = 4'b0;
      mode = 8'b0;
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0, 4) == 0) req = 4'($urandom);
         if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
         if (c % 137 == 136) begin
            pulse_rst();
            vectors++;
            if ({grant, led, busy, tick} !== 7'b0) begin
               errors++;
               $display("FAIL random_reset: cycle %0d got %b, want 0000000",
                        c, {grant, led, busy, tick});
            end
            release_rst();
         end
         step();
         vectors++;
         if ({grant, led, busy, tick} !== exp_vec()) begin
            errors++;
            $display("FAIL random_model: cycle %0d req=%b mode=%b got %b, want %b",
                     c, req, mode, {grant, led, busy, tick}, exp_vec());
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      req  = 4'b0;
      mode = 8'b0;
      model_reset();
      test_reset();
      test_fast_blink();
      test_slow_blink();
      test_preempt();
      test_release();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want completion");
      $fatal(1, "timeout");
   end

endmodule
